// File: rtl/peak_detector.sv
// peak_detector: hysteresis peak detector with post-fall hold-off, peak count and optional rise-to-rise period
// Ports: CLOCK_50/rst_n (sync, active-low); in_valid/x sample input;
//        peak/peak_val/peak_cnt excursion report; period/period_valid rise spacing; state FSM (LOW/HIGH/HOLD).
// Define PEAK_PERIOD_EN to build the period measurement; otherwise period and period_valid are 0.
module peak_detector #(
  parameter logic [7:0] HI_TH = 8'd160,
  parameter logic [7:0] LO_TH = 8'd96,
  parameter int HOLDOFF = 4,
  parameter int PERIOD_W = 16
) (
  input  logic                CLOCK_50,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [7:0]          x,
  output logic                peak,
  output logic [7:0]          peak_val,
  output logic [15:0]         peak_cnt,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic [1:0]          state
);
  localparam logic [1:0] LOW = 2'b00, HIGH = 2'b01, HOLD = 2'b10;
  localparam int HW = HOLDOFF > 1 ? $clog2(HOLDOFF + 1) : 1;
  logic [1:0] st, st_nxt;
  logic [7:0] run_max;
  logic [HW-1:0] hcnt;
  logic rise, fall;
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      st <= LOW;
      run_max <= '0;
      hcnt <= '0;
      peak <= 1'b0;
      peak_val <= '0;
      peak_cnt <= '0;
    end else begin
      st <= st_nxt;
      peak <= fall;
      if (rise) run_max <= x;
      else if (in_valid && st == HIGH && x > run_max) run_max <= x;
      if (fall) begin
        peak_val <= run_max;
        peak_cnt <= &peak_cnt ? peak_cnt : peak_cnt + 16'd1;
      end
      if (fall) hcnt <= HW'(HOLDOFF);
      else if (in_valid && st == HOLD && hcnt != '0) hcnt <= hcnt - HW'(1);
    end
  end
  // Out-of-range state 2'b11 recovers to LOW through the HOLD branch once hcnt is exhausted.
  always_comb begin
    st_nxt = !in_valid ? st :
             st == LOW  ? (rise ? HIGH : LOW) :
             st == HIGH ? (fall ? (HOLDOFF == 0 ? LOW : HOLD) : HIGH) :
             (hcnt <= HW'(1) ? LOW : HOLD);
  end
  always_comb begin
    rise = in_valid && st == LOW && x >= HI_TH;
    fall = in_valid && st == HIGH && x <= LO_TH;
  end
  assign state = st;
`ifdef PEAK_PERIOD_EN
  logic [PERIOD_W-1:0] pcnt, pinc;
  logic armed;
  // pinc counts the current sample, so a rise reports (previous rise, this rise].
  assign pinc = &pcnt ? pcnt : pcnt + PERIOD_W'(1);
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      pcnt <= '0;
      armed <= 1'b0;
      period <= '0;
      period_valid <= 1'b0;
    end else begin
      period_valid <= rise && armed;
      if (in_valid) pcnt <= rise ? '0 : pinc;
      if (rise) armed <= 1'b1;
      if (rise && armed) period <= pinc;
    end
  end
`else
  assign period = '0;
  assign period_valid = 1'b0;
`endif
endmodule
